// File: rtl/axis_packet_checker.sv
// AXI4-Stream sink: per-packet beat count, modular sum, error flag.
// Ports: aclk/areset, s_axis_* stream in, m_stat_* record out, pkt_count.
module axis_packet_checker #(
  parameter int                DATA_W     = 32,
  parameter int                MAX_BEATS  = 16,
  parameter int                LEN_W      = $clog2(MAX_BEATS + 1),
  parameter int                CHECK_DATA = 1,
  parameter logic [DATA_W-1:0] EXPECTED   = DATA_W'(32'hDEADBEEF)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic              m_stat_valid,
  input  logic              m_stat_ready,
  output logic [LEN_W-1:0]  m_stat_beats,
  output logic [DATA_W-1:0] m_stat_sum,
  output logic              m_stat_err,
  output logic [15:0]       pkt_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BEATS);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    beats_acc_q, beats_acc_d;
  logic [DATA_W-1:0]   sum_acc_q, sum_acc_d;
  logic                err_acc_q, err_acc_d;
  logic                stat_valid_q, stat_valid_d;
  logic [LEN_W-1:0]    stat_beats_q, stat_beats_d;
  logic [DATA_W-1:0]   stat_sum_q, stat_sum_d;
  logic                stat_err_q, stat_err_d;
  logic [15:0]         pkt_count_q, pkt_count_d;

  logic                tready;
  logic                beat;
  logic                at_max;
  logic                mism;
  logic [LEN_W-1:0]    beats_nxt;
  logic [DATA_W-1:0]   sum_nxt;
  logic                err_nxt;

  always_comb begin
    // A pending, unconsumed record stalls the whole stream.
    tready    = !stat_valid_q || m_stat_ready;
    beat      = s_axis_tvalid && tready;
    at_max    = (beats_acc_q == MAX_L);
    mism      = (CHECK_DATA != 0) && (s_axis_tdata != EXPECTED);
    beats_nxt = at_max ? beats_acc_q : beats_acc_q + LEN_W'(1);
    sum_nxt   = sum_acc_q + s_axis_tdata;
    // A beat arriving with the count already saturated is overlength.
    err_nxt   = err_acc_q | mism | at_max;

    state_d      = state_q;
    beats_acc_d  = beats_acc_q;
    sum_acc_d    = sum_acc_q;
    err_acc_d    = err_acc_q;
    stat_valid_d = stat_valid_q;
    stat_beats_d = stat_beats_q;
    stat_sum_d   = stat_sum_q;
    stat_err_d   = stat_err_q;
    pkt_count_d  = pkt_count_q;

    if (stat_valid_q && m_stat_ready) begin
      stat_valid_d = 1'b0;
    end

    if (beat) begin
      if (s_axis_tlast) begin
        state_d      = IDLE;
        beats_acc_d  = '0;
        sum_acc_d    = '0;
        err_acc_d    = 1'b0;
        stat_valid_d = 1'b1;
        stat_beats_d = beats_nxt;
        stat_sum_d   = sum_nxt;
        stat_err_d   = err_nxt;
        pkt_count_d  = pkt_count_q + 16'd1;
      end else begin
        state_d     = ACCUM;
        beats_acc_d = beats_nxt;
        sum_acc_d   = sum_nxt;
        err_acc_d   = err_nxt;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      beats_acc_q  <= '0;
      sum_acc_q    <= '0;
      err_acc_q    <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_beats_q <= '0;
      stat_sum_q   <= '0;
      stat_err_q   <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      beats_acc_q  <= beats_acc_d;
      sum_acc_q    <= sum_acc_d;
      err_acc_q    <= err_acc_d;
      stat_valid_q <= stat_valid_d;
      stat_beats_q <= stat_beats_d;
      stat_sum_q   <= stat_sum_d;
      stat_err_q   <= stat_err_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign s_axis_tready = tready;
  assign m_stat_valid  = stat_valid_q;
  assign m_stat_beats  = stat_beats_q;
  assign m_stat_sum    = stat_sum_q;
  assign m_stat_err    = stat_err_q;
  assign pkt_count     = pkt_count_q;

endmodule
